// File: rtl/gb10_workload_dispatcher_pkg.sv
// Shared types for the workload dispatcher: FSM states and the queued command format.
package gb10_dispatch_pkg;

    localparam int CMD_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } dispatch_state_e;

    typedef struct packed {
        logic [63:0]          hint;
        logic [CMD_CNT_W-1:0] cycles;
    } dispatch_cmd_t;

    // A zero-length command still occupies one RUN cycle.
    function automatic logic [CMD_CNT_W-1:0] run_length(input logic [CMD_CNT_W-1:0] cycles);
        return (cycles == '0) ? CMD_CNT_W'(1) : cycles;
    endfunction

endpackage

// File: rtl/gb10_workload_dispatcher_if.sv
// Generic valid/ready stream carrying one item of type T per accepted transfer.
interface gb10_workload_dispatcher_if #(
    parameter type T = logic
);
    logic valid;
    logic ready;
    T     data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gb10_workload_dispatcher_cmd_fifo.sv
// Synchronous command FIFO; a written entry becomes visible at the output only on the following cycle.
module gb10_cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                         clk,
    input  logic                         rst,
    gb10_workload_dispatcher_if.slave    in_s,
    gb10_workload_dispatcher_if.master   out_m,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign in_s.ready  = !full;
    assign out_m.valid = !empty;
    assign out_m.data  = mem[rd_ptr];
    assign push        = in_s.valid && in_s.ready;
    assign pop         = out_m.valid && out_m.ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_s.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gb10_workload_dispatcher.sv
// Drives queued workload hints to the CPU cluster for a fixed number of cycles and
// reports the performance-counter delta observed over each command.
module gb10_workload_dispatcher
    import gb10_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [63:0]      cmd_hint_i,
    input  logic [CNT_W-1:0] cmd_cycles_i,
    input  logic             abort_i,
    output logic [63:0]      workload_hint_o,
    input  logic [63:0]      perf_counter_i,
    output logic             stat_valid_o,
    output logic [63:0]      stat_delta_o,
    output logic             stat_aborted_o,
    output logic             busy_o,
    output logic [31:0]      done_count_o
);

    dispatch_state_e                     state_q;
    dispatch_state_e                     state_d;
    logic [63:0]                         hint_q;
    logic [63:0]                         base_q;
    logic [CNT_W-1:0]                    remaining_q;
    logic                                pop;
    logic                                last_run;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count;

    gb10_workload_dispatcher_if #(.T(dispatch_cmd_t)) push_if ();
    gb10_workload_dispatcher_if #(.T(dispatch_cmd_t)) pop_if ();

    assign push_if.valid = cmd_valid_i;
    assign push_if.data  = {cmd_hint_i, CMD_CNT_W'(cmd_cycles_i)};
    assign pop_if.ready  = pop;

    gb10_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (dispatch_cmd_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .in_s  (push_if),
        .out_m (pop_if),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = RUN;
            RUN:     if (last_run)    state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort shortens the active command; it is only meaningful while running.
    always_comb begin
        pop             = 1'b0;
        last_run        = 1'b0;
        workload_hint_o = '0;
        stat_valid_o    = 1'b0;
        unique case (state_q)
            IDLE:    pop = pop_if.valid;
            RUN: begin
                workload_hint_o = hint_q;
                last_run        = (remaining_q == CNT_W'(1)) || abort_i;
            end
            DRAIN:   stat_valid_o = 1'b1;
            default: ;
        endcase
        busy_o      = (state_q != IDLE) || (fifo_count != '0);
        cmd_ready_o = !fifo_full;
    end

    // The subtraction is modulo 2^64, so a counter wrap mid-command still yields the true delta.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hint_q         <= '0;
            base_q         <= '0;
            remaining_q    <= '0;
            stat_delta_o   <= '0;
            stat_aborted_o <= 1'b0;
            done_count_o   <= '0;
        end else begin
            if (pop) begin
                hint_q      <= pop_if.data.hint;
                remaining_q <= CNT_W'(run_length(pop_if.data.cycles));
                base_q      <= perf_counter_i;
            end else if (state_q == RUN) begin
                remaining_q <= remaining_q - CNT_W'(1);
            end
            if (last_run) begin
                stat_delta_o   <= perf_counter_i - base_q;
                stat_aborted_o <= abort_i && (remaining_q != CNT_W'(1));
                done_count_o   <= done_count_o + 32'd1;
            end
        end
    end

endmodule

// File: doc/gb10_workload_dispatcher.md
GB10_WORKLOAD_DISPATCHER -- requirements
Module: gb10_workload_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the per-command duration field.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid_i, input, 1, a command is offered.
REQ-006 SHALL have port cmd_ready_o, output, 1, the queue accepts a command.
REQ-007 SHALL have port cmd_hint_i, input, 64, the workload hint to drive.
REQ-008 SHALL have port cmd_cycles_i, input, CNT_W, the number of cycles to drive the hint.
REQ-009 SHALL have port abort_i, input, 1, terminates the active command.
REQ-010 SHALL have port workload_hint_o, output, 64, the hint to the CPU cluster.
REQ-011 SHALL have port perf_counter_i, input, 64, the CPU cluster performance counter.
REQ-012 SHALL have port stat_valid_o, output, 1, a one-cycle result strobe.
REQ-013 SHALL have port stat_delta_o, output, 64, the perf counter delta for the finished command.
REQ-014 SHALL have port stat_aborted_o, output, 1, the finished command was aborted; valid with the strobe.
REQ-015 SHALL have port busy_o, output, 1, the state is not IDLE or the queue is not empty.
REQ-016 SHALL have port done_count_o, output, 32, the number of completed plus aborted commands.

Function
REQ-017 SHALL push the command {hint, cycles} into the FIFO when cmd_valid_i && cmd_ready_o.
REQ-018 SHALL drive cmd_ready_o = !full; when full, a simultaneous pop SHALL NOT raise ready in the same cycle.
REQ-019 SHALL NOT bypass the FIFO: a command pushed into an empty FIFO is poppable no earlier than the next cycle.
REQ-020 SHALL use the FSM states IDLE, RUN, DRAIN.
REQ-021 SHALL, in IDLE with the FIFO not empty, pop the head, load the hint register, and load remaining = max(cycles, 1); base <= perf_counter_i; next state RUN.
REQ-022 SHALL drive workload_hint_o = the hint register in RUN only and 64'h0 in IDLE and DRAIN.
REQ-023 SHALL stay in RUN for exactly remaining cycles, decrementing each cycle; on the last RUN cycle the next state is DRAIN.
REQ-024 SHALL, on the RUN->DRAIN edge, register stat_delta_o <= perf_counter_i - base, modulo 2^64, so a wrap of perf_counter_i yields the correct difference.
REQ-025 SHALL hold stat_valid_o = 1 for exactly the one DRAIN cycle; DRAIN SHALL always go to IDLE next.
REQ-026 SHALL hold stat_delta_o and stat_aborted_o stable until the next strobe.
REQ-027 SHALL, when abort_i is high in a RUN cycle, make that cycle the last RUN cycle with the same delta capture and stat_aborted_o = 1.
REQ-028 SHALL ignore abort_i in IDLE and DRAIN; abort SHALL NOT flush the queue.
REQ-029 SHALL set stat_aborted_o = 0 when abort_i and natural expiry coincide on the last cycle.
REQ-030 SHALL increment done_count_o by 1 per stat strobe, wrapping at 2^32.
REQ-031 SHALL give each command an occupancy of 1 IDLE + N RUN + 1 DRAIN cycles, with no back-to-back RUN across commands.

Reset
REQ-032 SHALL, on rst_i, set the state to IDLE, empty the FIFO, set workload_hint_o=0, stat_valid_o=0, stat_delta_o=0, stat_aborted_o=0, done_count_o=0, busy_o=0, and cmd_ready_o=1 from the first cycle after reset.
REQ-033 SHALL, on reset mid-RUN, discard the active command and the queued commands with no stat strobe emitted.
REQ-034 SHALL give reset priority over push, pop and abort.

Structure
REQ-035 SHALL put the state enum (IDLE/RUN/DRAIN) and the packed struct dispatch_cmd_t {hint[63:0], cycles[CNT_W-1:0]} in the shared package gb10_dispatch_pkg.
REQ-036 SHALL implement the queue as the sub-module gb10_cmd_fifo, a synchronous FIFO with push/pop/full/empty and an occupancy count, parameterised by depth and type.

Verification
REQ-037 SHALL cover this scenario: perf_counter_i incrementing by 72 per cycle from 0, one command hint=0x5, cycles=4 -> hint 0x5 for 4 cycles, then a strobe with delta=288, aborted=0, and done_count_o=1.
REQ-038 SHALL cover this scenario: cycles=0 -> 1 RUN cycle, delta=72.
REQ-039 SHALL cover this scenario: 5 commands pushed back-to-back while stalled in a long command -> cmd_ready_o low after 4 accepted; the 5th is accepted after the first pop; all 5 strobes arrive in order.
REQ-040 SHALL cover this scenario: cycles=10 with abort_i pulsed in the 3rd RUN cycle -> hint is zero from the next cycle, delta=216, aborted=1, and the queued next command starts after DRAIN.
REQ-041 SHALL cover this scenario: base=64'hFFFF_FFFF_FFFF_FFF0 with +72/cycle, cycles=2 -> delta=144 across the wrap.
REQ-042 SHALL cover this scenario: rst_i asserted mid-RUN with 2 queued commands -> all outputs at reset values next cycle, no strobe, busy_o=0.
